// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM states, port indices, default widths.
// Build option: MEMARB_LOADER_EN enables the loader/debug (L) port.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRwait = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] PORT_M1   = 2'd0;
    localparam logic [1:0] PORT_M2   = 2'd1;
    localparam logic [1:0] PORT_L    = 2'd2;
    localparam logic [1:0] PORT_NONE = 2'd3;

`ifdef MEMARB_LOADER_EN
    localparam bit         LOADER_EN = 1'b1;
    // Pointer starts on the last port in rotation so Mem1 wins first.
    localparam logic [1:0] PTR_RESET = PORT_L;
`else
    localparam bit         LOADER_EN = 1'b0;
    localparam logic [1:0] PTR_RESET = PORT_M2;
`endif

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over Mem1 -> Mem2 -> L -> Mem1.
// The L request is masked off when MEMARB_LOADER_EN is not defined.
module rr_pick3
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] gnt_o,
    output logic [1:0] idx_o
);

    logic [2:0] req_m;
    logic [1:0] base;
    logic [1:0] cand;

    // Scan the three ports starting just after the last grant; first requester wins.
    always_comb begin
        gnt_o    = 3'b000;
        idx_o    = PORT_NONE;
        cand     = PORT_M1;
        req_m    = req_i;
        req_m[2] = req_i[2] & LOADER_EN;
        base     = (last_i == PORT_NONE) ? PORT_L : last_i;
        for (int i = 1; i <= 3; i++) begin
            cand = 2'((int'(base) + i) % 3);
            if (idx_o == PORT_NONE && req_m[cand]) begin
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between Mem1, Mem2
// and (with MEMARB_LOADER_EN defined) a loader/debug port L.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              Req1,
    input  logic              Write1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,
    input  logic              Req2,
    input  logic              Write2,
    input  logic [ADDR_W-1:0] Addr2,
    input  logic [DATA_W-1:0] WData2,
    output logic              Ack2,
    output logic [DATA_W-1:0] RData2,
`ifdef MEMARB_LOADER_EN
    input  logic              ReqL,
    input  logic              WriteL,
    input  logic [ADDR_W-1:0] AddrL,
    input  logic [DATA_W-1:0] WDataL,
    output logic              AckL,
    output logic [DATA_W-1:0] RDataL,
`endif
    output logic              RamEn,
    output logic              RamWe,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData,
    output logic              Busy,
    output logic [1:0]        GrantIdx
);

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        ptr_q, ptr_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
`ifdef MEMARB_LOADER_EN
    logic [DATA_W-1:0] rdatal_q, rdatal_d;
`endif

    logic [2:0] req_vec;
    logic [2:0] pick_gnt;
    logic [1:0] pick_idx;

`ifdef MEMARB_LOADER_EN
    assign req_vec = {ReqL, Req2, Req1};
`else
    assign req_vec = {1'b0, Req2, Req1};
`endif

    rr_pick3 u_pick (
        .req_i  (req_vec),
        .last_i (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // State and datapath registers; reset also discards any pending Ack.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q  <= StIdle;
            grant_q  <= PORT_NONE;
            ptr_q    <= PTR_RESET;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
`ifdef MEMARB_LOADER_EN
            rdatal_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
`ifdef MEMARB_LOADER_EN
            rdatal_q <= rdatal_d;
`endif
        end
    end

    // Next state: grant and latch in IDLE, capture read data in RWAIT.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
`ifdef MEMARB_LOADER_EN
        rdatal_d = rdatal_q;
`endif
        case (state_q)
            StIdle: begin
                grant_d = PORT_NONE;
                if (|req_vec) begin
                    state_d = StIssue;
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    case (pick_gnt)
                        3'b010: begin
                            wr_d    = Write2;
                            addr_d  = Addr2;
                            wdata_d = WData2;
                        end
`ifdef MEMARB_LOADER_EN
                        3'b100: begin
                            wr_d    = WriteL;
                            addr_d  = AddrL;
                            wdata_d = WDataL;
                        end
`endif
                        default: begin
                            wr_d    = Write1;
                            addr_d  = Addr1;
                            wdata_d = WData1;
                        end
                    endcase
                end
            end
            StIssue: state_d = wr_q ? StDone : StRwait;
            StRwait: begin
                state_d = StDone;
                case (grant_q)
                    PORT_M1: rdata1_d = RamRData;
                    PORT_M2: rdata2_d = RamRData;
`ifdef MEMARB_LOADER_EN
                    PORT_L:  rdatal_d = RamRData;
`endif
                    default: ;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        RamEn    = (state_q == StIssue);
        RamWe    = (state_q == StIssue) && wr_q;
        RamAddr  = addr_q;
        RamWData = wdata_q;
        Busy     = (state_q != StIdle);
        GrantIdx = (state_q == StIdle) ? PORT_NONE : grant_q;
        Ack1     = (state_q == StDone) && (grant_q == PORT_M1);
        Ack2     = (state_q == StDone) && (grant_q == PORT_M2);
        RData1   = rdata1_q;
        RData2   = rdata2_q;
`ifdef MEMARB_LOADER_EN
        AckL     = (state_q == StDone) && (grant_q == PORT_L);
        RDataL   = rdatal_q;
`endif
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (both MEMARB_LOADER_EN builds).
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          Rst;
    logic          Req1, Write1, Req2, Write2;
    logic [AW-1:0] Addr1, Addr2;
    logic [DW-1:0] WData1, WData2;
    logic          Ack1, Ack2;
    logic [DW-1:0] RData1, RData2;
`ifdef MEMARB_LOADER_EN
    logic          ReqL, WriteL, AckL;
    logic [AW-1:0] AddrL;
    logic [DW-1:0] WDataL, RDataL;
`endif
    logic          RamEn, RamWe, Busy;
    logic [AW-1:0] RamAddr;
    logic [DW-1:0] RamWData, RamRData;
    logic [1:0]    GrantIdx;

    int n_cmp = 0;
    int n_err = 0;
    bit saw_gidx2 = 1'b0;
    int who;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK      (CLK),
        .Rst      (Rst),
        .Req1     (Req1),
        .Write1   (Write1),
        .Addr1    (Addr1),
        .WData1   (WData1),
        .Ack1     (Ack1),
        .RData1   (RData1),
        .Req2     (Req2),
        .Write2   (Write2),
        .Addr2    (Addr2),
        .WData2   (WData2),
        .Ack2     (Ack2),
        .RData2   (RData2),
`ifdef MEMARB_LOADER_EN
        .ReqL     (ReqL),
        .WriteL   (WriteL),
        .AddrL    (AddrL),
        .WDataL   (WDataL),
        .AckL     (AckL),
        .RDataL   (RDataL),
`endif
        .RamEn    (RamEn),
        .RamWe    (RamWe),
        .RamAddr  (RamAddr),
        .RamWData (RamWData),
        .RamRData (RamRData),
        .Busy     (Busy),
        .GrantIdx (GrantIdx)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM model, read data valid the cycle after RamEn.
    logic [DW-1:0] mem [0:65535];
    always @(posedge CLK) begin
        if (RamEn) begin
            if (RamWe) mem[RamAddr] <= RamWData;
            else       RamRData <= mem[RamAddr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (GrantIdx == 2'd2) saw_gidx2 = 1'b1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    // Returns the port whose Ack fires next, or -1 if none within the budget.
    task automatic wait_ack(output int w);
        w = -1;
        for (int i = 0; i < 12 && w < 0; i++) begin
            tick();
            if (Ack1) w = 0;
            else if (Ack2) w = 1;
`ifdef MEMARB_LOADER_EN
            else if (AckL) w = 2;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0020] = 16'h5A5A;
        RamRData = '0;
        Rst = 1'b1;
        Req1 = 0; Write1 = 0; Addr1 = '0; WData1 = '0;
        Req2 = 0; Write2 = 0; Addr2 = '0; WData2 = '0;
`ifdef MEMARB_LOADER_EN
        ReqL = 0; WriteL = 0; AddrL = '0; WDataL = '0;
`endif
        #2;
        check_eq("rst_ramen", RamEn, 0);
        check_eq("rst_ramwe", RamWe, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_gidx", GrantIdx, 3);
        check_eq("rst_ack1", Ack1, 0);
        check_eq("rst_ramaddr", RamAddr, 0);
        check_eq("rst_rdata1", RData1, 0);
        tick();
        Rst = 1'b0;

        // Mem1 write 0xBEEF to 0x0010
        Req1 = 1; Write1 = 1; Addr1 = 16'h0010; WData1 = 16'hBEEF;
        tick();
        check_eq("wr_ramen", RamEn, 1);
        check_eq("wr_ramwe", RamWe, 1);
        check_eq("wr_ramaddr", RamAddr, 16'h0010);
        check_eq("wr_ramwdata", RamWData, 16'hBEEF);
        check_eq("wr_gidx", GrantIdx, 0);
        check_eq("wr_ack_early", Ack1, 0);
        Addr1 = 16'h0077; WData1 = 16'h1111;   // post-grant changes must not reach RAM
        tick();
        check_eq("wr_ack1", Ack1, 1);
        check_eq("wr_ramen_done", RamEn, 0);
        Req1 = 0; Write1 = 0;
        tick();
        check_eq("wr_ack_drop", Ack1, 0);
        check_eq("wr_idle_busy", Busy, 0);
        check_eq("wr_idle_gidx", GrantIdx, 3);

        // Mem2 read of 0x0010
        Req2 = 1; Write2 = 0; Addr2 = 16'h0010;
        tick();
        check_eq("rd_ramen", RamEn, 1);
        check_eq("rd_ramwe", RamWe, 0);
        check_eq("rd_ramaddr", RamAddr, 16'h0010);
        check_eq("rd_gidx", GrantIdx, 1);
        tick();
        check_eq("rd_rwait_en", RamEn, 0);
        check_eq("rd_rwait_ack", Ack2, 0);
        check_eq("rd_rwait_busy", Busy, 1);
        tick();
        check_eq("rd_ack2", Ack2, 1);
        check_eq("rd_rdata2", RData2, 16'hBEEF);
        check_eq("rd_rdata1_kept", RData1, 0);
        Req2 = 0;
        tick();

        // Simultaneous requests after reset
        do_reset();
        check_eq("rst2_rdata2", RData2, 0);
`ifdef MEMARB_LOADER_EN
        for (int r = 0; r < 2; r++) begin
            Req1 = 1; Req2 = 1; ReqL = 1; AddrL = 16'h0010;
            wait_ack(who); check_eq("rr3_a", who, 0); check_eq("rr3_a_gidx", GrantIdx, 0);
            Req1 = 0;
            wait_ack(who); check_eq("rr3_b", who, 1); check_eq("rr3_b_gidx", GrantIdx, 1);
            Req2 = 0;
            wait_ack(who); check_eq("rr3_c", who, 2); check_eq("rr3_c_gidx", GrantIdx, 2);
            check_eq("rr3_rdatal", RDataL, 16'hBEEF);
            ReqL = 0;
        end
`else
        Req1 = 1; Req2 = 1;
        for (int r = 0; r < 2; r++) begin
            wait_ack(who); check_eq("rr2_m1", who, 0);
            wait_ack(who); check_eq("rr2_m2", who, 1);
        end
        Req1 = 0; Req2 = 0;
        check_eq("rr2_no_gidx2", saw_gidx2, 0);
`endif
        tick();

        // Mem1 continuous, Mem2 once: Mem1, Mem2, Mem1
        Req1 = 1; Req2 = 1;
        wait_ack(who); check_eq("starve_1", who, 0);
        wait_ack(who); check_eq("starve_2", who, 1);
        Req2 = 0;
        wait_ack(who); check_eq("starve_3", who, 0);
        Req1 = 0;
        tick();
        check_eq("starve_idle", Busy, 0);

        // Reset during ISSUE of a write
        Req1 = 1; Write1 = 1; Addr1 = 16'h0020; WData1 = 16'h1234;
        tick();
        check_eq("rstmid_we_pre", RamWe, 1);
        Rst = 1'b1;
        #1;
        check_eq("rstmid_we", RamWe, 0);
        check_eq("rstmid_en", RamEn, 0);
        check_eq("rstmid_busy", Busy, 0);
        check_eq("rstmid_gidx", GrantIdx, 3);
        Req1 = 0; Write1 = 0;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rstmid_no_ack", Ack1, 0);
        end
        Req2 = 1; Write2 = 0; Addr2 = 16'h0020;
        wait_ack(who);
        check_eq("rstmid_rd_port", who, 1);
        check_eq("rstmid_mem_kept", RData2, 16'h5A5A);
        Req2 = 0;
        tick();

`ifndef MEMARB_LOADER_EN
        check_eq("no_gidx2_final", saw_gidx2, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
